// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, writeback-register layout and memory-FSM state type
// for the memory/writeback stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_DONE
  } mem_state_e;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

  // Stack pops read through the old stack pointer carried in valA.
  function automatic logic addr_from_vala(input logic [3:0] icode);
    return (icode == I_POPQ) || (icode == I_RET);
  endfunction

endpackage

// File: rtl/y86_dmem_ctrl.sv
// Data-memory request/ack handshake FSM (IDLE/BUSY/DONE) with registered bus
// outputs; the BUSY abort counter exists only when Y86_MEM_TIMEOUT_EN is defined.
module y86_dmem_ctrl
  import y86_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        ack_i,
  input  logic [63:0] rdata_i,
  input  logic        w_stall_i,
  output logic        req_o,
  output logic        we_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [63:0] rdata_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  mem_state_e  state_q;
  logic        req_q;
  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;

`ifdef Y86_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef Y86_MEM_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (go_i) begin
            req_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            rdata_q <= '0;
            state_q <= MEM_BUSY;
`ifdef Y86_MEM_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
          end
        end
        MEM_BUSY: begin
          if (ack_i) begin
            rdata_q <= rdata_i;
            req_q   <= 1'b0;
            state_q <= MEM_DONE;
          end
`ifdef Y86_MEM_TIMEOUT_EN
          // An ack on the final allowed cycle still wins over the abort.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= MEM_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        MEM_DONE: begin
          if (!w_stall_i) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign req_o   = req_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign done_o  = (state_q == MEM_DONE);
  assign stall_o = ((state_q == MEM_IDLE) && go_i) || (state_q == MEM_BUSY);

`ifdef Y86_MEM_TIMEOUT_EN
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/y86_mem_wb_stage.sv
// Y86-64 memory stage plus W pipeline register: decodes the M bundle into a
// data-memory access, bounds-checks it and loads W. Optional: Y86_MEM_TIMEOUT_EN.
module y86_mem_wb_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES     = 8192,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic        m_stall,
  output logic [2:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [2:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  // Highest legal start address of an 8-byte access; a plain 64-bit compare
  // against it cannot wrap the way addr+7 would.
  localparam logic [63:0] LAST_ADDR = 64'(DMEM_BYTES - 8);

  logic        is_rd;
  logic        is_wr;
  logic        mem_op;
  logic        addr_ok;
  logic        go;
  logic [63:0] acc_addr;
  logic        done;
  logic        timed_out;
  logic [63:0] rdata_cap;
  w_reg_t      w_q;
  w_reg_t      w_d;

  assign is_rd    = is_mem_read(M_icode);
  assign is_wr    = is_mem_write(M_icode);
  assign acc_addr = addr_from_vala(M_icode) ? M_valA : M_valE;
  assign addr_ok  = (acc_addr <= LAST_ADDR);
  assign mem_op   = (M_stat == STAT_AOK) && (is_rd || is_wr);
  assign go       = mem_op && addr_ok;

  y86_dmem_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .go_i     (go),
    .we_i     (is_wr),
    .addr_i   (acc_addr),
    .wdata_i  (M_valA),
    .ack_i    (dmem_ack),
    .rdata_i  (dmem_rdata),
    .w_stall_i(W_stall),
    .req_o    (dmem_req),
    .we_o     (dmem_we),
    .addr_o   (dmem_addr),
    .wdata_o  (dmem_wdata),
    .stall_o  (m_stall),
    .done_o   (done),
    .timeout_o(timed_out),
    .rdata_o  (rdata_cap)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    m_stat = STAT_AOK;
    if (M_stat != STAT_AOK) begin
      m_stat = M_stat;
    end else if (mem_op && !addr_ok) begin
      m_stat = STAT_ADR;
    end else if (done && timed_out) begin
      m_stat = STAT_ADR;
    end
  end

  assign m_valM = (done && is_rd && !timed_out) ? rdata_cap : 64'd0;

  always_comb begin
    w_d = w_q;
    if (W_stall) begin
      w_d = w_q;
    end else if (m_stall) begin
      w_d = W_BUBBLE;
    end else begin
      w_d = '{
        stat:  m_stat,
        icode: M_icode,
        val_e: M_valE,
        val_m: m_valM,
        dst_e: M_dstE,
        dst_m: M_dstM
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= W_BUBBLE;
    end else begin
      w_q <= w_d;
    end
  end

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;

endmodule

// File: tb/tb_y86_mem_wb_stage.sv
// Self-checking bench for y86_mem_wb_stage: directed scenarios plus randomized
// instructions checked against a transaction-level model of the stage.
module tb_y86_mem_wb_stage;

  localparam int DMEM_BYTES = 8192;
  localparam int TMO        = 4;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [3:0] NOP = 4'h1;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ = 4'h6;
  localparam logic [3:0] CALL = 4'h8;
  localparam logic [3:0] RET = 4'h9;
  localparam logic [3:0] PUSHQ = 4'hA;
  localparam logic [3:0] POPQ = 4'hB;
  localparam logic [3:0] RN = 4'hF;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } wexp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        m_stall;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;

  int    checks   = 0;
  int    failures = 0;
  wexp_t w_exp;

  y86_mem_wb_stage #(
    .DMEM_BYTES    (DMEM_BYTES),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .M_stat    (M_stat),
    .M_icode   (M_icode),
    .M_valE    (M_valE),
    .M_valA    (M_valA),
    .M_dstE    (M_dstE),
    .M_dstM    (M_dstM),
    .W_stall   (W_stall),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .m_stall   (m_stall),
    .m_stat    (m_stat),
    .m_valM    (m_valM),
    .W_stat    (W_stat),
    .W_icode   (W_icode),
    .W_valE    (W_valE),
    .W_valM    (W_valM),
    .W_dstE    (W_dstE),
    .W_dstM    (W_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag);
    check({tag, ".W_stat"},  W_stat,  w_exp.stat);
    check({tag, ".W_icode"}, W_icode, w_exp.icode);
    check({tag, ".W_valE"},  W_valE,  w_exp.vale);
    check({tag, ".W_valM"},  W_valM,  w_exp.valm);
    check({tag, ".W_dstE"},  W_dstE,  w_exp.dste);
    check({tag, ".W_dstM"},  W_dstM,  w_exp.dstm);
  endtask

  function automatic wexp_t bubble();
    wexp_t b;
    b = '{stat: AOK, icode: NOP, vale: 64'd0, valm: 64'd0, dste: RN, dstm: RN};
    return b;
  endfunction

  // 0 = no memory access, 1 = read, 2 = write.
  function automatic int mem_kind(input logic [3:0] icode);
    case (icode)
      MRMOVQ, POPQ, RET:    return 1;
      RMMOVQ, PUSHQ, CALL:  return 2;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [63:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 64'($urandom_range(0, DMEM_BYTES - 8));
      3:       return 64'(DMEM_BYTES - 8);
      4:       return 64'(DMEM_BYTES - 7);
      default: return {32'hFFFF_FFFF, $urandom()};
    endcase
  endfunction

  // One instruction through the stage, from first presentation on M until W loads it.
  task automatic exec(input logic [2:0] stat, input logic [3:0] icode,
                      input logic [63:0] vale, input logic [63:0] vala,
                      input logic [3:0] dste, input logic [3:0] dstm,
                      input int ack_at, input logic [63:0] rdata,
                      input int wstall_cycles, input bit ack_with_wstall);
    int          kind;
    logic [63:0] addr;
    bit          attempt;
    bit          legal;
    bit          issue;
    logic [2:0]  e_stat;
    logic [63:0] e_valm;
    int          stall_cnt;
    int          req_cnt;

    kind    = mem_kind(icode);
    addr    = (icode == POPQ || icode == RET) ? vala : vale;
    attempt = (stat == AOK) && (kind != 0);
    legal   = (addr <= 64'(DMEM_BYTES - 8));
    issue   = attempt && legal;
    e_stat  = (stat != AOK) ? stat : ((attempt && !legal) ? ADR : AOK);
    e_valm  = (issue && kind == 1) ? rdata : 64'd0;

    M_stat = stat; M_icode = icode; M_valE = vale; M_valA = vala;
    M_dstE = dste; M_dstM = dstm;
    W_stall = 1'b0; dmem_ack = 1'b0;
    #1;

    if (issue) begin
      stall_cnt = 1;
      req_cnt   = 0;
      check("issue.m_stall", m_stall, 1'b1);
      @(posedge clk); #1;
      w_exp = bubble();
      check_w("issue_bubble");
      check("issue.req", dmem_req, 1'b1);
      check("issue.we", dmem_we, (kind == 2));
      check("issue.addr", dmem_addr, addr);
      if (kind == 2) check("issue.wdata", dmem_wdata, vala);
      for (int k = 1; k <= ack_at; k++) begin
        dmem_ack   = (k == ack_at);
        dmem_rdata = (k == ack_at) ? rdata : {$urandom(), $urandom()};
        W_stall    = (k == ack_at) && ack_with_wstall;
        #1;
        if (m_stall === 1'b1) stall_cnt++;
        if (dmem_req === 1'b1) req_cnt++;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
      check_w("busy_hold");
      check("busy.stall_cycles", 64'(stall_cnt), 64'(1 + ack_at));
      check("busy.req_cycles", 64'(req_cnt), 64'(ack_at));
    end

    for (int s = 0; s < wstall_cycles; s++) begin
      W_stall  = 1'b1;
      dmem_ack = 1'($urandom_range(0, 1));
      dmem_rdata = {$urandom(), $urandom()};
      #1;
      check("wstall.m_stall", m_stall, 1'b0);
      check("wstall.m_stat", m_stat, e_stat);
      check("wstall.m_valM", m_valM, e_valm);
      check("wstall.req", dmem_req, 1'b0);
      @(posedge clk); #1;
      check_w("wstall_hold");
    end

    W_stall = 1'b0; dmem_ack = 1'b0;
    #1;
    check("load.m_stall", m_stall, 1'b0);
    check("load.m_stat", m_stat, e_stat);
    check("load.m_valM", m_valM, e_valm);
    check("load.req", dmem_req, 1'b0);
    @(posedge clk); #1;
    w_exp = '{stat: e_stat, icode: icode, vale: vale, valm: e_valm, dste: dste, dstm: dstm};
    check_w("load");
  endtask

  initial begin
    int req_cnt;

    rst_n = 1'b0;
    M_stat = AOK; M_icode = NOP; M_valE = '0; M_valA = '0; M_dstE = RN; M_dstM = RN;
    W_stall = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    w_exp = bubble();
    check_w("reset");
    check("reset.req", dmem_req, 1'b0);
    check("reset.we", dmem_we, 1'b0);
    check("reset.addr", dmem_addr, 64'd0);
    check("reset.wdata", dmem_wdata, 64'd0);
    check("reset.m_stall", m_stall, 1'b0);
    rst_n = 1'b1;
    #1;

    // mrmovq, ack on third BUSY cycle
    exec(AOK, MRMOVQ, 64'h100, 64'h0, RN, 4'h3, 3, 64'hDEAD, 0, 1'b0);
    // rmmovq, ack in first BUSY cycle
    exec(AOK, RMMOVQ, 64'h40, 64'h55, RN, RN, 1, 64'h0, 0, 1'b0);
    // popq one byte past the last legal address
    exec(AOK, POPQ, 64'h8, 64'(DMEM_BYTES - 7), 4'h4, 4'h0, 1, 64'h0, 0, 1'b0);
    // OPq held by W_stall for two cycles
    exec(AOK, OPQ, 64'h7, 64'h0, 4'h2, RN, 1, 64'h0, 2, 1'b0);
    // last legal address, ack together with W_stall, then DONE held
    exec(AOK, MRMOVQ, 64'(DMEM_BYTES - 8), 64'h0, RN, 4'h1, 2, 64'h1234_5678_9ABC_DEF0, 2, 1'b1);
    // address near 2^64 must not wrap into range
    exec(AOK, PUSHQ, 64'hFFFF_FFFF_FFFF_FFFC, 64'h99, 4'h4, RN, 1, 64'h0, 0, 1'b0);
    // non-AOK status suppresses the access
    exec(3'd4, RMMOVQ, 64'h10, 64'h77, RN, RN, 1, 64'h0, 0, 1'b0);
`ifndef Y86_MEM_TIMEOUT_EN
    // without the timeout the request waits indefinitely for ack
    exec(AOK, RET, 64'h0, 64'h200, 4'h4, RN, 10, 64'hCAFE, 0, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 4) != 0) ? AOK : 3'($urandom_range(2, 4));
      exec(st, 4'($urandom_range(0, 11)), pick_addr(), pick_addr(),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(1, TMO), {$urandom(), $urandom()},
           $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // reset while BUSY, then a late ack
    M_stat = AOK; M_icode = MRMOVQ; M_valE = 64'h200; M_valA = '0; M_dstE = RN; M_dstM = 4'h6;
    W_stall = 1'b0; dmem_ack = 1'b0;
    #1;
    @(posedge clk); #1;
    check("rst_busy.req", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    M_icode = NOP; M_valE = '0; M_dstM = RN;
    #1;
    w_exp = bubble();
    check_w("rst_busy");
    check("rst_busy.req", dmem_req, 1'b0);
    check("rst_busy.addr", dmem_addr, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'hBEEF;
    #1;
    check("late_ack.m_stall", m_stall, 1'b0);
    check("late_ack.m_valM", m_valM, 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack.req", dmem_req, 1'b0);
    check_w("late_ack");

`ifdef Y86_MEM_TIMEOUT_EN
    // no ack ever: request dropped after TMO BUSY cycles, stage reports ADR
    M_stat = AOK; M_icode = MRMOVQ; M_valE = 64'h80; M_valA = '0; M_dstE = RN; M_dstM = 4'h5;
    #1;
    @(posedge clk); #1;
    req_cnt = 0;
    for (int k = 0; k < 2 * TMO && dmem_req === 1'b1; k++) begin
      req_cnt++;
      @(posedge clk); #1;
    end
    check("tmo.req_cycles", 64'(req_cnt), 64'(TMO));
    check("tmo.m_stall", m_stall, 1'b0);
    check("tmo.m_stat", m_stat, ADR);
    check("tmo.m_valM", m_valM, 64'd0);
    @(posedge clk); #1;
    w_exp = '{stat: ADR, icode: MRMOVQ, vale: 64'h80, valm: 64'd0, dste: RN, dstm: 4'h5};
    check_w("tmo_load");
`else
    req_cnt = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
